// File: rtl/div_seq_pkg.sv
// Shared encodings for the EX-stage divide sequencer.
//   div_state_t    : FSM state encoding (IDLE/CALC/SIGN/DONE, binary)
//   DIV_CONTROL    : ALU control code for signed divide
//   DIVU_CONTROL   : ALU control code for unsigned divide
//   FUNCT_DIV/DIVU : SPECIAL-opcode funct values the decoder maps to start/signed_div
package div_seq_pkg;

    typedef enum logic [1:0] {
        DIV_ST_IDLE = 2'd0,
        DIV_ST_CALC = 2'd1,
        DIV_ST_SIGN = 2'd2,
        DIV_ST_DONE = 2'd3
    } div_state_t;

    localparam logic [7:0] DIV_CONTROL  = 8'b0001_1010;
    localparam logic [7:0] DIVU_CONTROL = 8'b0001_1011;

    localparam logic [5:0] FUNCT_DIV    = 6'b01_1010;
    localparam logic [5:0] FUNCT_DIVU   = 6'b01_1011;

endpackage

// File: rtl/div_seq_step.sv
// One combinational restoring-division step.
//   rem, quo, dv       : partial remainder, shifting dividend/quotient, divisor magnitude
//   rem_nxt, quo_nxt   : values after shifting one dividend bit in and a trial subtract
module div_seq_step #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem,
    input  logic [DATA_W-1:0] quo,
    input  logic [DATA_W-1:0] dv,
    output logic [DATA_W-1:0] rem_nxt,
    output logic [DATA_W-1:0] quo_nxt
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;
    logic            ge;

    // Extra top bit keeps the compare exact even if the shifted remainder reaches 2^W.
    always_comb begin
        shifted = {rem, quo[DATA_W-1]};
        diff    = shifted - {1'b0, dv};
        ge      = (shifted >= {1'b0, dv});
        rem_nxt = ge ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
        quo_nxt = {quo[DATA_W-2:0], ge};
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU in EX.
// Holds the pipeline (stall_o) from an accepted start until the result is ready.
//   clk, rst    : clock, synchronous active-high reset
//   start       : EX holds a divide (level); accepted only in IDLE
//   signed_div  : 1 = DIV, 0 = DIVU
//   a, b        : dividend / divisor, sampled on accepted start
//   annul       : EX flush, aborts any operation
//   stall_o     : combinational pipeline hold
//   busy        : CALC or SIGN in progress
//   done        : one-cycle result-valid pulse
//   hi, lo      : remainder / quotient
// Optional build macro DIV_ZERO_FAST_EN: b==0 goes straight from IDLE to DONE.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              signed_div,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              annul,
    output logic              stall_o,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

    div_state_t        state, state_nxt;
    logic [DATA_W-1:0] rem_q, quo_q, div_q;
    logic [DATA_W-1:0] rem_nxt, quo_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              sign_q, sign_r;
    logic              accept;
    logic              a_neg, b_neg;
    logic [DATA_W-1:0] a_mag, b_mag;

    div_seq_step #(.DATA_W(DATA_W)) u_step (
        .rem     (rem_q),
        .quo     (quo_q),
        .dv      (div_q),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

    always_comb begin
        a_neg = signed_div & a[DATA_W-1];
        b_neg = signed_div & b[DATA_W-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    assign accept  = (state == DIV_ST_IDLE) & start & ~annul;
    assign busy    = (state == DIV_ST_CALC) | (state == DIV_ST_SIGN);
    assign done    = (state == DIV_ST_DONE) & ~annul;
    assign stall_o = busy | accept;

    // CALC spends one extra cycle after the last step (cnt==DATA_W) before SIGN,
    // giving the DATA_W+2 edge latency from acceptance to DONE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            DIV_ST_IDLE: begin
                if (start) begin
`ifdef DIV_ZERO_FAST_EN
                    state_nxt = (b == '0) ? DIV_ST_DONE : DIV_ST_CALC;
`else
                    state_nxt = DIV_ST_CALC;
`endif
                end
            end
            DIV_ST_CALC: if (cnt == CNT_LAST) state_nxt = DIV_ST_SIGN;
            DIV_ST_SIGN: state_nxt = DIV_ST_DONE;
            DIV_ST_DONE: state_nxt = DIV_ST_IDLE;
            default:     state_nxt = DIV_ST_IDLE;
        endcase
        if (annul) state_nxt = DIV_ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= DIV_ST_IDLE;
            rem_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
            cnt    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                rem_q  <= '0;
                quo_q  <= a_mag;
                div_q  <= b_mag;
                cnt    <= '0;
                sign_q <= a_neg ^ b_neg;
                sign_r <= a_neg;
`ifdef DIV_ZERO_FAST_EN
                if (b == '0) begin
                    hi <= a;
                    lo <= '1;
                end
`endif
            end
            if ((state == DIV_ST_CALC) && (cnt != CNT_LAST) && !annul) begin
                rem_q <= rem_nxt;
                quo_q <= quo_nxt;
                cnt   <= cnt + CNT_W'(1);
            end
            if ((state == DIV_ST_SIGN) && !annul) begin
                lo <= sign_q ? -quo_q : quo_q;
                hi <= sign_r ? -rem_q : rem_q;
            end
        end
    end

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;
    import div_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, signed_div, annul;
    logic [31:0] a, b;
    logic        stall_o, busy, done;
    logic [31:0] hi, lo;

    int tests  = 0;
    int failed = 0;

    div_seq #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .a          (a),
        .b          (b),
        .annul      (annul),
        .stall_o    (stall_o),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 35;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start held until done; returns after checking latency, result and single-cycle done.
    task automatic run_div(input string tag, input logic sd, input logic [31:0] av,
                           input logic [31:0] bv, input int lat,
                           input logic [31:0] elo, input logic [31:0] ehi);
        int   n;
        logic seen;
        signed_div = sd;
        a          = av;
        b          = bv;
        start      = 1'b1;
        #1;
        check({tag, "_stall_start"}, {31'd0, stall_o}, 32'd1);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            tick();
            n++;
            if (done) seen = 1'b1;
            else check({tag, "_stall"}, {31'd0, stall_o}, 32'd1);
        end
        check({tag, "_lat"}, n, lat);
        check({tag, "_lo"}, lo, elo);
        check({tag, "_hi"}, hi, ehi);
        check({tag, "_stall_done"}, {31'd0, stall_o}, 32'd0);
        start = 1'b0;
        tick();
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int ndone, at_n, n2;
        logic [31:0] lo1, hi1;

        rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0;
        a = '0; b = '0;
        repeat (3) tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_hi", hi, 32'd0);
        rst = 1'b0;
        tick();

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 35, 32'd14, 32'd2);
        run_div("div_m7_2",   1'b1, 32'hFFFF_FFF9, 32'd2, 35, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("div_7_m2",   1'b1, 32'd7, 32'hFFFF_FFFE, 35, 32'hFFFF_FFFD, 32'd1);
        run_div("div_ovf",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 35, 32'h8000_0000, 32'd0);
        run_div("divu_ovf",   1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 35, 32'd0, 32'h8000_0000);

        // Annul on the 10th CALC cycle: back to IDLE, no done, result registers untouched.
        signed_div = 1'b0; a = 32'd1000; b = 32'd10; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        annul = 1'b1;
        tick();
        annul = 1'b0;
        check("annul_busy", {31'd0, busy}, 32'd0);
        check("annul_lo", lo, 32'd0);
        check("annul_hi", hi, 32'h8000_0000);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) ndone++;
            tick();
        end
        check("annul_no_done", ndone, 0);
        run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 35, 32'd3, 32'd0);

        // Reset in the middle of CALC clears everything.
        signed_div = 1'b0; a = 32'd50; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_lo", lo, 32'd0);
        check("rstmid_hi", hi, 32'd0);
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_stall", {31'd0, stall_o}, 32'd0);
        tick();

        run_div("divu_5_0", 1'b0, 32'd5, 32'd0, ZERO_LAT, 32'hFFFF_FFFF, 32'd5);

        // Start held for 40 cycles with operands changed mid-operation.
        signed_div = 1'b0; a = 32'd200; b = 32'd10; start = 1'b1;
        ndone = 0; at_n = 0; lo1 = '0; hi1 = '0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (n == 10) begin
                a = 32'd77;
                b = 32'd5;
            end
            if (done) begin
                ndone++;
                at_n = n;
                lo1  = lo;
                hi1  = hi;
            end
        end
        check("held_ndone", ndone, 1);
        check("held_at", at_n, 35);
        check("held_lo", lo1, 32'd20);
        check("held_hi", hi1, 32'd0);
        start = 1'b0;
        n2 = 0;
        while (!done && n2 < 60) begin
            tick();
            n2++;
        end
        check("second_lat", n2, 31);
        check("second_lo", lo, 32'd15);
        check("second_hi", hi, 32'd2);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
